// File: rtl/arb_pkg.sv
// Shared constants, grant record and round-robin pick function for the 4:1 arbiter.
package arb_pkg;
  localparam int N_CH  = 4;
  localparam int SEL_W = 2;

  typedef struct packed {
    logic             any;
    logic [SEL_W-1:0] grant;
  } pick_t;

  // Scans channels last+1 .. last+4 (mod 4). The backwards loop lets the
  // nearest requester after `last` overwrite the farther ones.
  function automatic pick_t rr_pick(input logic [N_CH-1:0] req, input logic [SEL_W-1:0] last);
    pick_t            p;
    logic [SEL_W-1:0] idx;
    p.any   = |req;
    p.grant = last;
    for (int k = N_CH; k >= 1; k--) begin
      idx = last + SEL_W'(k);
      if (req[idx]) p.grant = idx;
    end
    return p;
  endfunction
endpackage

// File: rtl/mux_4_1.sv
// Existing 4-bit 4:1 data-path multiplexer, purely combinational.
module mux_4_1 #(
  parameter int W = 4
) (
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  input  logic [1:0]   sel,
  output logic [W-1:0] y
);
  always_comb begin
    unique case (sel)
      2'd0: y = d0;
      2'd1: y = d1;
      2'd2: y = d2;
      default: y = d3;
    endcase
  end
endmodule

// File: rtl/arbiter_4_1_rr.sv
// Four-channel round-robin arbiter feeding mux_4_1 into a registered
// valid/ready output stage.
module arbiter_4_1_rr
  import arb_pkg::*;
#(
  parameter int W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  in_valid,
  output logic [N_CH-1:0]  in_ready,
  input  logic [W-1:0]     d0,
  input  logic [W-1:0]     d1,
  input  logic [W-1:0]     d2,
  input  logic [W-1:0]     d3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [SEL_W-1:0] out_sel
);
  logic [SEL_W-1:0] last;
  pick_t            pick;
  logic             can_load;
  logic             load;
  logic [W-1:0]     mux_y;

  assign pick     = rr_pick(in_valid, last);
  assign can_load = !out_valid || out_ready;
  assign load     = can_load && pick.any;

  // NOTE: default first so every path assigns in_ready and no latch is inferred.
  // rst_n gates it so nothing is accepted while reset is held.
  always_comb begin
    in_ready = '0;
    if (rst_n && load) in_ready[pick.grant] = 1'b1;
  end

  mux_4_1 #(.W(W)) u_mux (
    .d0  (d0),
    .d1  (d1),
    .d2  (d2),
    .d3  (d3),
    .sel (pick.grant),
    .y   (mux_y)
  );

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      last      <= SEL_W'(N_CH - 1);
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= mux_y;
      out_sel   <= pick.grant;
      last      <= pick.grant;
    end else if (can_load) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_arbiter_4_1_rr.sv
// Directed and randomized checks of arbiter_4_1_rr against a behavioural
// round-robin model.
module tb_arbiter_4_1_rr;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] in_valid;
  logic [3:0] in_ready;
  logic [3:0] d0, d1, d2, d3;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic [1:0] out_sel;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  int       m_last;
  bit       m_valid;
  bit [3:0] m_data;
  int       m_sel;

  always #5 clk = ~clk;

  arbiter_4_1_rr #(.W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d0        (d0),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant(input logic [3:0] req);
    for (int k = 1; k <= 4; k++) begin
      if (req[(m_last + k) % 4]) return (m_last + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] chan_data(input int ch);
    case (ch)
      0: return d0;
      1: return d1;
      2: return d2;
      default: return d3;
    endcase
  endfunction

  task automatic model_reset();
    m_last  = 3;
    m_valid = 1'b0;
    m_data  = 4'h0;
    m_sel   = 0;
  endtask

  // Entered at posedge+1; leaves at the following posedge+1.
  task automatic cycle(input logic [3:0] v, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic [3:0] d, input logic rdy);
    int         g;
    bit         can_load;
    logic [3:0] exp_ready;
    in_valid  = v;
    d0 = a; d1 = b; d2 = c; d3 = d;
    out_ready = rdy;
    @(negedge clk);
    g         = model_grant(v);
    can_load  = !m_valid || rdy;
    exp_ready = (can_load && g >= 0) ? 4'(1 << g) : 4'b0000;
    check("in_ready",  {4'h0, in_ready},  {4'h0, exp_ready});
    check("out_valid", {7'h0, out_valid}, {7'h0, m_valid});
    check("out_data",  {4'h0, out_data},  {4'h0, m_data});
    check("out_sel",   {6'h0, out_sel},   8'(m_sel));
    @(posedge clk);
    if (can_load && g >= 0) begin
      m_valid = 1'b1;
      m_data  = chan_data(g);
      m_sel   = g;
      m_last  = g;
    end else if (can_load) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  // Reset asserted just after an edge, held across one edge, released
  // right after it so the next cycle starts aligned.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_out_valid", {7'h0, out_valid}, 8'h00);
    check("rst_out_data",  {4'h0, out_data},  8'h00);
    check("rst_out_sel",   {6'h0, out_sel},   8'h00);
    check("rst_in_ready",  {4'h0, in_ready},  8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] seq [6];
    rst_n     = 1'b0;
    in_valid  = 4'b0000;
    out_ready = 1'b0;
    d0 = 4'h0; d1 = 4'h0; d2 = 4'h0; d3 = 4'h0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Single request on channel 0
    cycle(4'b0001, 4'hA, 4'h0, 4'h0, 4'h0, 1'b1);
    check("single_valid", {7'h0, out_valid}, 8'h01);
    check("single_data",  {4'h0, out_data},  8'h0A);
    check("single_sel",   {6'h0, out_sel},   8'h00);

    // All four requesting: A B C D A B
    do_reset();
    seq = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hA, 4'hB};
    for (int i = 0; i < 6; i++) begin
      cycle(4'b1111, 4'hA, 4'hB, 4'hC, 4'hD, 1'b1);
      check("rr_data", {4'h0, out_data}, {4'h0, seq[i]});
      check("rr_sel",  {6'h0, out_sel},  8'(i % 4));
    end

    // Backpressure holding B, then C follows
    for (int i = 0; i < 3; i++) begin
      cycle(4'b1111, 4'hA, 4'hB, 4'hC, 4'hD, 1'b0);
      check("bp_data",  {4'h0, out_data}, 8'h0B);
      check("bp_valid", {7'h0, out_valid}, 8'h01);
    end
    cycle(4'b1111, 4'hA, 4'hB, 4'hC, 4'hD, 1'b1);
    check("bp_next_data", {4'h0, out_data}, 8'h0C);

    // Sparse: get last=1, then in_valid=1001 grants 3 then 0
    do_reset();
    cycle(4'b0010, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1);
    cycle(4'b1001, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1);
    check("sparse_sel3", {6'h0, out_sel}, 8'h03);
    cycle(4'b1001, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1);
    check("sparse_sel0", {6'h0, out_sel}, 8'h00);

    // Idle drains the register and holds data
    cycle(4'b0000, 4'h5, 4'h6, 4'h7, 4'h8, 1'b1);
    check("idle_valid", {7'h0, out_valid}, 8'h00);
    check("idle_data",  {4'h0, out_data},  8'h01);

    // Reset mid-transfer with a stalled word, then channel 0 wins
    cycle(4'b1111, 4'h9, 4'hA, 4'hB, 4'hC, 1'b0);
    check("stall_valid", {7'h0, out_valid}, 8'h01);
    in_valid = 4'b1111;
    #1;
    do_reset();
    cycle(4'b1111, 4'h9, 4'hA, 4'hB, 4'hC, 1'b1);
    check("post_rst_sel",  {6'h0, out_sel},  8'h00);
    check("post_rst_data", {4'h0, out_data}, 8'h09);

    // Randomized traffic with ~70% out_ready
    for (int i = 0; i < 300; i++) begin
      cycle(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
            ($urandom_range(0, 9) < 7));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
